// File: rtl/core_pkg.sv
// Shared RV32 core definitions: load/store funct3 encodings and the MEM-stage state type.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store strobes/replication and load extraction/extension.
module mem_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Reserved encodings (011, 110, 111) fall through to full-word behaviour.
    always_comb begin
        wstrb       = 4'b1111;
        wdata       = store_data;
        load_result = rdata;
        case (funct3)
            F3_B, F3_BU: begin
                wstrb       = 4'b0001 << addr;
                wdata       = {4{store_data[7:0]}};
                load_result = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
            end
            F3_H, F3_HU: begin
                wstrb       = addr[1] ? 4'b1100 : 4'b0011;
                wdata       = {2{store_data[15:0]}};
                load_result = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
            end
            default: begin
                wstrb       = 4'b1111;
                wdata       = store_data;
                load_result = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, runs the req/gnt/rvalid data-bus transaction
// for loads and stores, and hands the completed bundle to WB with a valid/ready handshake.
module mem_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    output logic        mem_ready,
    input  logic [31:0] pc_ex,
    input  logic [31:0] inst_ex,
    input  logic [31:0] alu_res_ex,
    input  logic [31:0] store_data_ex,
    input  logic [31:0] csr_rdata_ex,
    input  logic [31:0] csr_wdata_ex,
    input  logic        mem_ren_ex,
    input  logic        mem_wen_ex,
    input  logic [2:0]  mem_funct3_ex,
    input  logic [2:0]  sel_rf_wdata_ex,
    input  logic        ecall_en_ex,
    input  logic        mret_en_ex,
    input  logic        rf_wen_ex,
    input  logic        csr_wen_ex,
    input  logic        ebreak_ex,

    output logic        mem_valid,
    input  logic        wb_ready,
    output logic [31:0] pc_mem,
    output logic [31:0] inst_mem,
    output logic [31:0] alu_res_mem,
    output logic [31:0] csr_rdata_mem,
    output logic [31:0] csr_wdata_mem,
    output logic [31:0] load_data_mem,
    output logic [2:0]  sel_rf_wdata_mem,
    output logic        ecall_en_mem,
    output logic        mret_en_mem,
    output logic        rf_wen_mem,
    output logic        csr_wen_mem,
    output logic        ebreak_mem,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    mem_state_t  r_state;
    logic        r_valid;
    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [2:0]  r_funct3;
    logic [31:0] r_store_data;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_alu_res;
    logic [31:0] r_csr_rdata;
    logic [31:0] r_csr_wdata;
    logic [31:0] r_load_data;
    logic [2:0]  r_sel_rf_wdata;
    logic        r_ecall_en;
    logic        r_mret_en;
    logic        r_rf_wen;
    logic        r_csr_wen;
    logic        r_ebreak;

    logic        w_ready_go;
    logic        w_mem_ready;
    logic        w_in_req;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_result;

    mem_align u_mem_align (
        .funct3      (r_funct3),
        .addr        (r_alu_res[1:0]),
        .store_data  (r_store_data),
        .rdata       (dmem_rdata),
        .wstrb       (w_wstrb),
        .wdata       (w_wdata),
        .load_result (w_load_result)
    );

    assign w_ready_go  = (r_state == DONE) || (r_valid && !r_mem_ren && !r_mem_wen);
    assign w_mem_ready = !r_valid || (w_ready_go && wb_ready);
    assign w_in_req    = (r_state == REQ);

    assign mem_valid  = r_valid && w_ready_go;
    assign mem_ready  = w_mem_ready;
    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req && r_mem_wen;
    assign dmem_addr  = {r_alu_res[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_wstrb = (w_in_req && r_mem_wen) ? w_wstrb : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_valid        <= 1'b0;
            r_mem_ren      <= 1'b0;
            r_mem_wen      <= 1'b0;
            r_funct3       <= 3'b000;
            r_store_data   <= 32'b0;
            r_pc           <= 32'b0;
            r_inst         <= 32'b0;
            r_alu_res      <= 32'b0;
            r_csr_rdata    <= 32'b0;
            r_csr_wdata    <= 32'b0;
            r_load_data    <= 32'b0;
            r_sel_rf_wdata <= 3'b000;
            r_ecall_en     <= 1'b0;
            r_mret_en      <= 1'b0;
            r_rf_wen       <= 1'b0;
            r_csr_wen      <= 1'b0;
            r_ebreak       <= 1'b0;
        end else if (w_mem_ready) begin
            // Handoff slot: either take the next EX bundle or go empty.
            if (ex_valid) begin
                r_valid        <= 1'b1;
                r_state        <= (mem_ren_ex || mem_wen_ex) ? REQ : IDLE;
                r_mem_ren      <= mem_ren_ex;
                r_mem_wen      <= mem_wen_ex;
                r_funct3       <= mem_funct3_ex;
                r_store_data   <= store_data_ex;
                r_pc           <= pc_ex;
                r_inst         <= inst_ex;
                r_alu_res      <= alu_res_ex;
                r_csr_rdata    <= csr_rdata_ex;
                r_csr_wdata    <= csr_wdata_ex;
                r_load_data    <= 32'b0;
                r_sel_rf_wdata <= sel_rf_wdata_ex;
                r_ecall_en     <= ecall_en_ex;
                r_mret_en      <= mret_en_ex;
                r_rf_wen       <= rf_wen_ex;
                r_csr_wen      <= csr_wen_ex;
                r_ebreak       <= ebreak_ex;
            end else begin
                r_valid <= 1'b0;
                r_state <= IDLE;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (dmem_gnt) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        r_state <= DONE;
                        if (r_mem_ren) begin
                            r_load_data <= w_load_result;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign pc_mem           = r_pc;
    assign inst_mem         = r_inst;
    assign alu_res_mem      = r_alu_res;
    assign csr_rdata_mem    = r_csr_rdata;
    assign csr_wdata_mem    = r_csr_wdata;
    assign load_data_mem    = r_load_data;
    assign sel_rf_wdata_mem = r_sel_rf_wdata;
    assign ecall_en_mem     = r_ecall_en;
    assign mret_en_mem      = r_mret_en;
    assign rf_wen_mem       = r_rf_wen;
    assign csr_wen_mem      = r_csr_wen;
    assign ebreak_mem       = r_ebreak;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected WB bundles, a monitor pops on handoff.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_ready;
    logic [31:0] pc_ex, inst_ex, alu_res_ex, store_data_ex, csr_rdata_ex, csr_wdata_ex;
    logic        mem_ren_ex, mem_wen_ex;
    logic [2:0]  mem_funct3_ex, sel_rf_wdata_ex;
    logic        ecall_en_ex, mret_en_ex, rf_wen_ex, csr_wen_ex, ebreak_ex;
    logic        mem_valid, wb_ready;
    logic [31:0] pc_mem, inst_mem, alu_res_mem, csr_rdata_mem, csr_wdata_mem, load_data_mem;
    logic [2:0]  sel_rf_wdata_mem;
    logic        ecall_en_mem, mret_en_mem, rf_wen_mem, csr_wen_mem, ebreak_mem;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        rf_wen;
        logic [2:0]  sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .mem_ready(mem_ready),
        .pc_ex(pc_ex), .inst_ex(inst_ex), .alu_res_ex(alu_res_ex),
        .store_data_ex(store_data_ex), .csr_rdata_ex(csr_rdata_ex), .csr_wdata_ex(csr_wdata_ex),
        .mem_ren_ex(mem_ren_ex), .mem_wen_ex(mem_wen_ex), .mem_funct3_ex(mem_funct3_ex),
        .sel_rf_wdata_ex(sel_rf_wdata_ex), .ecall_en_ex(ecall_en_ex), .mret_en_ex(mret_en_ex),
        .rf_wen_ex(rf_wen_ex), .csr_wen_ex(csr_wen_ex), .ebreak_ex(ebreak_ex),
        .mem_valid(mem_valid), .wb_ready(wb_ready),
        .pc_mem(pc_mem), .inst_mem(inst_mem), .alu_res_mem(alu_res_mem),
        .csr_rdata_mem(csr_rdata_mem), .csr_wdata_mem(csr_wdata_mem), .load_data_mem(load_data_mem),
        .sel_rf_wdata_mem(sel_rf_wdata_mem), .ecall_en_mem(ecall_en_mem), .mret_en_mem(mret_en_mem),
        .rf_wen_mem(rf_wen_mem), .csr_wen_mem(csr_wen_mem), .ebreak_mem(ebreak_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every WB handoff must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!rst && mem_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_bundle: pc_mem=0x%08h with no expected entry", pc_mem);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", pc_mem, e.pc);
                check("sb_inst", inst_mem, e.inst);
                check("sb_alu_res", alu_res_mem, e.alu);
                check("sb_load_data", load_data_mem, e.ld);
                check("sb_rf_wen", {31'b0, rf_wen_mem}, {31'b0, e.rf_wen});
                check("sb_sel", {29'b0, sel_rf_wdata_mem}, {29'b0, e.sel});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic ren, input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] ld);
        exp_t e;
        ex_valid = 1'b1;
        pc_ex = pc;
        inst_ex = ~pc;
        alu_res_ex = addr;
        store_data_ex = sdata;
        mem_ren_ex = ren;
        mem_wen_ex = wen;
        mem_funct3_ex = f3;
        rf_wen_ex = !wen;
        sel_rf_wdata_ex = ren ? 3'd1 : (wen ? 3'd0 : 3'd2);
        e.pc = pc;
        e.inst = ~pc;
        e.alu = addr;
        e.ld = ld;
        e.rf_wen = !wen;
        e.sel = ren ? 3'd1 : (wen ? 3'd0 : 3'd2);
        exp_q.push_back(e);
    endtask

    // Load/store: capture, gnt_wait idle REQ cycles, grant, one RESP cycle, then DONE (optionally stalled).
    task automatic mem_op(input string tag, input logic [31:0] pc, input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gnt_wait, input int wb_wait,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic [31:0] e_ld);
        logic [31:0] e_addr;
        e_addr = {addr[31:2], 2'b00};
        drive_ex(pc, ren, wen, f3, addr, sdata, e_ld);
        @(negedge clk);
        check({tag, "_ready_at_capture"}, {31'b0, mem_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            @(negedge clk);
            check({tag, "_req_held"}, {31'b0, dmem_req}, 32'd1);
            check({tag, "_addr_held"}, dmem_addr, e_addr);
            check({tag, "_no_valid_wait"}, {31'b0, mem_valid}, 32'd0);
            step();
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        check({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        check({tag, "_we"}, {31'b0, dmem_we}, {31'b0, wen});
        check({tag, "_addr"}, dmem_addr, e_addr);
        check({tag, "_wstrb"}, {28'b0, dmem_wstrb}, {28'b0, e_strb});
        if (wen) check({tag, "_wdata"}, dmem_wdata, e_wdata);
        check({tag, "_ready_busy"}, {31'b0, mem_ready}, 32'd0);
        step();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        check({tag, "_req_resp"}, {31'b0, dmem_req}, 32'd0);
        check({tag, "_no_valid_resp"}, {31'b0, mem_valid}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'hFFFF_FFFF;
        if (wb_wait > 0) wb_ready = 1'b0;
        for (int i = 0; i < wb_wait; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, {31'b0, mem_valid}, 32'd1);
            check({tag, "_stall_ready"}, {31'b0, mem_ready}, 32'd0);
            check({tag, "_stall_alu"}, alu_res_mem, addr);
            check({tag, "_stall_ld"}, load_data_mem, e_ld);
            check({tag, "_stall_pc"}, pc_mem, pc);
            step();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_done"}, {31'b0, mem_valid}, 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0;
        pc_ex = 0; inst_ex = 0; alu_res_ex = 0; store_data_ex = 0;
        csr_rdata_ex = 32'h0C5A_0001; csr_wdata_ex = 32'h0C5A_0002;
        mem_ren_ex = 0; mem_wen_ex = 0; mem_funct3_ex = 0; sel_rf_wdata_ex = 0;
        ecall_en_ex = 0; mret_en_ex = 0; rf_wen_ex = 0; csr_wen_ex = 0; ebreak_ex = 0;
        wb_ready = 1'b1;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        step();
        step();
        @(negedge clk);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        check("rst_dmem_wstrb", {28'b0, dmem_wstrb}, 32'd0);
        check("rst_alu_res", alu_res_mem, 32'd0);
        check("rst_load_data", load_data_mem, 32'd0);
        step();
        rst = 1'b0;

        // Back-to-back non-memory ops.
        drive_ex(32'h100, 1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 32'h0);
        step();
        drive_ex(32'h104, 1'b0, 1'b0, 3'b010, 32'h0000_5678, 32'h0, 32'h0);
        @(negedge clk);
        check("alu_valid_c1", {31'b0, mem_valid}, 32'd1);
        check("alu_res_c1", alu_res_mem, 32'h0000_1234);
        check("alu_ready_c1", {31'b0, mem_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        check("alu2_valid_c2", {31'b0, mem_valid}, 32'd1);
        check("alu2_res_c2", alu_res_mem, 32'h0000_5678);
        step();
        @(negedge clk);
        check("alu_idle_c3", {31'b0, mem_valid}, 32'd0);
        step();

        //         tag    pc       ren   wen   f3      addr          sdata         rdata         gw wbw strb     wdata         load
        mem_op("lb",   32'h200, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80);
        mem_op("lhu",  32'h204, 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 4, 0, 4'b0000, 32'h0,        32'h0000_BEEF);
        mem_op("sb",   32'h208, 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'h0,        0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        mem_op("sh",   32'h20C, 1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_CAFE, 32'h0,        1, 0, 4'b1100, 32'hCAFE_CAFE, 32'h0);
        mem_op("sw",   32'h210, 1'b0, 1'b1, 3'b010, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0,        0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        mem_op("lw",   32'h214, 1'b1, 1'b0, 3'b010, 32'h0000_3003, 32'h0,        32'h1234_5678, 0, 3, 4'b0000, 32'h0,        32'h1234_5678);
        mem_op("lh",   32'h218, 1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0,        32'h0000_8001, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8001);
        mem_op("lbu",  32'h21C, 1'b1, 1'b0, 3'b100, 32'h0000_0006, 32'h0,        32'h00F1_0000, 0, 0, 4'b0000, 32'h0,        32'h0000_00F1);

        // Reset during RESP; the late rvalid must be dropped.
        ex_valid = 1'b1;
        pc_ex = 32'h300; inst_ex = 32'h0; alu_res_ex = 32'h0000_0040;
        mem_ren_ex = 1'b1; mem_wen_ex = 1'b0; mem_funct3_ex = 3'b010;
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstmid_valid", {31'b0, mem_valid}, 32'd0);
        check("rstmid_req", {31'b0, dmem_req}, 32'd0);
        check("rstmid_ready", {31'b0, mem_ready}, 32'd1);
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rstmid_valid_after", {31'b0, mem_valid}, 32'd0);
        check("rstmid_load_data", load_data_mem, 32'd0);
        check("rstmid_req_after", {31'b0, dmem_req}, 32'd0);
        step();

        // Recovery: a plain op still flows after the aborted load.
        drive_ex(32'h400, 1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0);
        step();
        ex_valid = 1'b0;
        step();
        step();

        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
